// File: rtl/nested_interrupt_ctl.sv
// nested_interrupt_ctl: multi-level interrupt controller with nested pre-emption.
// Sources are captured as level or rising-edge requests. The enabled pending
// source with the highest priority is presented to the CPU as a vector address.
// A service stack of {id, level} entries lets a strictly higher level pre-empt
// the one currently being serviced.
// Optional feature macro: INT_SW_TRIGGER_EN adds the sw_int_set software trigger port.
//
// Handshake: int_gen is "valid" and int_ack is "ready". A vector is accepted
// on a rising clk edge where int_gen and int_ack are both high. While int_gen
// is high, int_addr stays stable. The controller may withdraw int_gen without
// a transfer when the requested source stops qualifying. int_ack is ignored
// while int_gen is low.
module nested_interrupt_ctl #(
  parameter int                    NUM_OF_INT = 8,
  parameter int                    PRIO_BITS  = 2,
  parameter int                    ADDR_WIDTH = 8,
  parameter logic [ADDR_WIDTH-1:0] VEC_BASE   = 8'h03,
  parameter int                    VEC_STRIDE = 8
) (
  input  logic                            clk,
  input  logic                            reset_n,
  input  logic                            global_int_enable,
  input  logic [NUM_OF_INT-1:0]           int_enable_mask,
  input  logic [NUM_OF_INT-1:0]           int_level1_pulse0,
  input  logic [NUM_OF_INT*PRIO_BITS-1:0] int_priority,
  input  logic [NUM_OF_INT-1:0]           int_pins,
  input  logic                            int_ack,
  input  logic                            ret_int,
`ifdef INT_SW_TRIGGER_EN
  input  logic [NUM_OF_INT-1:0]           sw_int_set,
`endif
  output logic                            int_gen,
  output logic [ADDR_WIDTH-1:0]           int_addr,
  output logic [NUM_OF_INT-1:0]           int_pending,
  output logic                            int_in_service,
  output logic [PRIO_BITS-1:0]            int_active_level,
  output logic [1:0]                      dbg_state,
  output logic [((NUM_OF_INT > 1) ? $clog2(NUM_OF_INT) : 1)-1:0] dbg_top_id
);

  localparam int ID_W  = (NUM_OF_INT > 1) ? $clog2(NUM_OF_INT) : 1;
  localparam int DEPTH = 1 << PRIO_BITS;
  localparam int SP_W  = $clog2(DEPTH + 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ARB  = 2'd1,
    S_REQ  = 2'd2
  } state_t;

  state_t                  state, state_next;
  logic [NUM_OF_INT-1:0]   pins_s, int_pins_d1, pin_rise;
  logic [NUM_OF_INT-1:0]   pend_en, pend_next, ack_clr;
  logic                    cand_found, eligible;
  logic [ID_W-1:0]         cand_id;
  logic [PRIO_BITS-1:0]    cand_lvl;
  logic [ADDR_WIDTH-1:0]   addr_calc, addr_next;
  logic                    gen_next, push, ack_hit;
  logic [ID_W-1:0]         cur_id, id_next;
  logic [PRIO_BITS-1:0]    cur_lvl, lvl_next;
  logic [ID_W-1:0]         stk_id  [DEPTH];
  logic [PRIO_BITS-1:0]    stk_lvl [DEPTH];
  logic [SP_W-1:0]         sp, sp_pop, sp_next;
  logic                    push_ok;
  logic [PRIO_BITS-1:0]    top_idx, push_idx, top_lvl;
`ifdef INT_SW_TRIGGER_EN
  logic [NUM_OF_INT-1:0]   sw_hold, sw_hold_next;
`endif

  assign pin_rise = pins_s & ~int_pins_d1;
  assign pend_en  = int_pending & int_enable_mask;

  // Pick the enabled pending source with the highest priority, lowest index on ties.
  always_comb begin
    cand_found = 1'b0;
    cand_id    = '0;
    cand_lvl   = '0;
    for (int i = 0; i < NUM_OF_INT; i++) begin
      if (pend_en[i] && (!cand_found || int_priority[i*PRIO_BITS +: PRIO_BITS] > cand_lvl)) begin
        cand_found = 1'b1;
        cand_id    = ID_W'(i);
        cand_lvl   = int_priority[i*PRIO_BITS +: PRIO_BITS];
      end
    end
  end

  // Top-of-stack view; an empty stack reads as level 0.
  always_comb begin
    top_idx    = PRIO_BITS'(sp - 1'b1);
    top_lvl    = (sp == '0) ? '0 : stk_lvl[top_idx];
    dbg_top_id = (sp == '0) ? '0 : stk_id[top_idx];
  end

  assign eligible  = cand_found && ((sp == '0) || (cand_lvl > top_lvl));
  assign addr_calc = ADDR_WIDTH'(32'(VEC_BASE) + 32'(VEC_STRIDE) * 32'(cand_id));

  // Request FSM: next state, request outputs and stack push decision.
  always_comb begin
    state_next = state;
    gen_next   = int_gen;
    addr_next  = int_addr;
    id_next    = cur_id;
    lvl_next   = cur_lvl;
    push       = 1'b0;
    ack_hit    = 1'b0;
    case (state)
      S_IDLE: begin
        if (global_int_enable && eligible) state_next = S_ARB;
      end
      S_ARB: begin
        if (global_int_enable && eligible) begin
          id_next    = cand_id;
          lvl_next   = cand_lvl;
          addr_next  = addr_calc;
          gen_next   = 1'b1;
          state_next = S_REQ;
        end else begin
          state_next = S_IDLE;
        end
      end
      S_REQ: begin
        if (int_ack) begin
          push       = 1'b1;
          ack_hit    = 1'b1;
          gen_next   = 1'b0;
          state_next = S_IDLE;
        end else if (!int_pending[cur_id] || !int_enable_mask[cur_id] || !global_int_enable) begin
          gen_next   = 1'b0;
          state_next = S_IDLE;
        end
      end
      default: begin
        gen_next   = 1'b0;
        state_next = S_IDLE;
      end
    endcase
  end

  // Acknowledge clears the pending bit of the accepted source only.
  always_comb begin
    ack_clr = '0;
    for (int i = 0; i < NUM_OF_INT; i++) begin
      ack_clr[i] = ack_hit && (cur_id == ID_W'(i));
    end
  end

  // Pending next value: level sources follow the pin, pulse sources are sticky with set winning.
  always_comb begin
    pend_next = '0;
`ifdef INT_SW_TRIGGER_EN
    sw_hold_next = (sw_hold & ~ack_clr) | sw_int_set;
    for (int i = 0; i < NUM_OF_INT; i++) begin
      if (int_level1_pulse0[i]) pend_next[i] = pins_s[i] | sw_hold_next[i];
      else pend_next[i] = (int_pending[i] & ~ack_clr[i]) | pin_rise[i] | sw_int_set[i];
    end
`else
    for (int i = 0; i < NUM_OF_INT; i++) begin
      if (int_level1_pulse0[i]) pend_next[i] = pins_s[i];
      else pend_next[i] = (int_pending[i] & ~ack_clr[i]) | pin_rise[i];
    end
`endif
  end

  // Stack pointer: pop first, then push, saturating at full depth.
  always_comb begin
    sp_pop   = (ret_int && (sp != '0)) ? sp - 1'b1 : sp;
    push_ok  = push && (sp_pop < SP_W'(DEPTH));
    sp_next  = push_ok ? sp_pop + 1'b1 : sp_pop;
    push_idx = PRIO_BITS'(sp_pop);
  end

  // FSM state and request registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= S_IDLE;
      int_gen  <= 1'b0;
      int_addr <= '0;
      cur_id   <= '0;
      cur_lvl  <= '0;
    end else begin
      state    <= state_next;
      int_gen  <= gen_next;
      int_addr <= addr_next;
      cur_id   <= id_next;
      cur_lvl  <= lvl_next;
    end
  end

  // Pin sampling, edge history and pending register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pins_s      <= '0;
      int_pins_d1 <= '0;
      int_pending <= '0;
`ifdef INT_SW_TRIGGER_EN
      sw_hold     <= '0;
`endif
    end else begin
      pins_s      <= int_pins;
      int_pins_d1 <= pins_s;
      int_pending <= pend_next;
`ifdef INT_SW_TRIGGER_EN
      sw_hold     <= sw_hold_next;
`endif
    end
  end

  // Service stack of {id, level} entries.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sp <= '0;
      for (int k = 0; k < DEPTH; k++) begin
        stk_id[k]  <= '0;
        stk_lvl[k] <= '0;
      end
    end else begin
      sp <= sp_next;
      if (push_ok) begin
        stk_id[push_idx]  <= cur_id;
        stk_lvl[push_idx] <= cur_lvl;
      end
    end
  end

  assign int_in_service   = (sp != '0);
  assign int_active_level = top_lvl;
  assign dbg_state        = state;

endmodule

// File: tb/tb_nested_interrupt_ctl.sv
// Bench for nested_interrupt_ctl (8 sources, 2-bit priority, base 8'h03, stride 8).
module tb_nested_interrupt_ctl;

  localparam int N = 8;

  logic        clk, reset_n, global_int_enable, int_ack, ret_int;
  logic [7:0]  int_enable_mask, int_level1_pulse0, int_pins;
  logic [15:0] int_priority;
  logic        int_gen, int_in_service;
  logic [7:0]  int_addr, int_pending;
  logic [1:0]  int_active_level, dbg_state;
  logic [2:0]  dbg_top_id;
`ifdef INT_SW_TRIGGER_EN
  logic [7:0]  sw_int_set;
`endif

  int vectors, miscompares;

  // Reference model: pending flags, per-source priority and a stack of serviced entries.
  int prio_m[N];
  bit model_pend[N];
  int stk_lvl_q[$];
  int stk_id_q[$];

  nested_interrupt_ctl dut (
    .clk(clk), .reset_n(reset_n), .global_int_enable(global_int_enable),
    .int_enable_mask(int_enable_mask), .int_level1_pulse0(int_level1_pulse0),
    .int_priority(int_priority), .int_pins(int_pins), .int_ack(int_ack), .ret_int(ret_int),
`ifdef INT_SW_TRIGGER_EN
    .sw_int_set(sw_int_set),
`endif
    .int_gen(int_gen), .int_addr(int_addr), .int_pending(int_pending),
    .int_in_service(int_in_service), .int_active_level(int_active_level),
    .dbg_state(dbg_state), .dbg_top_id(dbg_top_id)
  );

  // Clock and watchdog.
  initial clk = 1'b0;
  always #5 clk = ~clk;
  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  function automatic logic [7:0] vec_of(input int id);
    return 8'(3 + 8 * id);
  endfunction

  function automatic logic [7:0] pend_vec();
    logic [7:0] v;
    v = '0;
    for (int i = 0; i < N; i++) v[i] = model_pend[i];
    return v;
  endfunction

  function automatic int model_level();
    return (stk_lvl_q.size() != 0) ? stk_lvl_q[$] : 0;
  endfunction

  // Walk levels from the top down; a source is served only above the active level.
  function automatic int exp_winner();
    int floor_lvl;
    if (!global_int_enable) return -1;
    floor_lvl = (stk_lvl_q.size() != 0) ? stk_lvl_q[$] : -1;
    for (int lv = 3; lv > floor_lvl; lv--)
      for (int i = 0; i < N; i++)
        if (model_pend[i] && int_enable_mask[i] && prio_m[i] == lv) return i;
    return -1;
  endfunction

  // ---------------- driver tasks ----------------
  task automatic set_prio(input int id, input int p);
    int_priority[id*2 +: 2] = 2'(p);
    prio_m[id] = p;
  endtask

  task automatic pulse_pins(input logic [7:0] m);
    @(negedge clk);
    int_pins = m;
    for (int i = 0; i < N; i++) if (m[i] && !int_level1_pulse0[i]) model_pend[i] = 1'b1;
    @(negedge clk);
    int_pins = '0;
  endtask

  task automatic wait_gen(input int bound, output bit ok);
    ok = 1'b0;
    for (int k = 0; k < bound; k++) begin
      if (int_gen === 1'b1) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
  endtask

  task automatic do_ack(input int id);
    int_ack = 1'b1;
    @(negedge clk);
    int_ack = 1'b0;
    if (!int_level1_pulse0[id]) model_pend[id] = 1'b0;
    stk_lvl_q.push_back(prio_m[id]);
    stk_id_q.push_back(id);
  endtask

  task automatic do_ret();
    ret_int = 1'b1;
    @(negedge clk);
    ret_int = 1'b0;
    if (stk_lvl_q.size() != 0) begin
      void'(stk_lvl_q.pop_back());
      void'(stk_id_q.pop_back());
    end
  endtask

  task automatic quiet(input int n, output bit seen);
    seen = 1'b0;
    repeat (n) begin
      @(negedge clk);
      if (int_gen !== 1'b0) seen = 1'b1;
    end
  endtask

  // Serve every request the model says is eligible, checking vector and stack.
  task automatic drain();
    int id;
    bit ok;
    bit seen;
    for (int k = 0; k < 20; k++) begin
      id = exp_winner();
      if (id < 0) begin
        quiet(6, seen);
        vectors++;
        if (seen) begin
          miscompares++;
          $display("FAIL drain_idle: int_gen got 1 expected 0 (level %0d)", model_level());
        end
        return;
      end
      wait_gen(12, ok);
      vectors++;
      if (!ok) begin
        miscompares++;
        $display("FAIL drain_timeout: no int_gen, expected vector %h", vec_of(id));
        return;
      end
      vectors++;
      if (int_addr !== vec_of(id)) begin
        miscompares++;
        $display("FAIL drain_addr: got %h expected %h", int_addr, vec_of(id));
      end
      do_ack(id);
      vectors++;
      if ({int_in_service, int_active_level, dbg_top_id} !== {1'b1, 2'(model_level()), 3'(id)}) begin
        miscompares++;
        $display("FAIL drain_stack: svc/lvl/id got %b/%0d/%0d expected 1/%0d/%0d",
                 int_in_service, int_active_level, dbg_top_id, model_level(), id);
      end
    end
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    reset_n = 1'b0; global_int_enable = 1'b0; int_enable_mask = '0; int_level1_pulse0 = '0;
    int_priority = '0; int_pins = '0; int_ack = 1'b0; ret_int = 1'b0;
`ifdef INT_SW_TRIGGER_EN
    sw_int_set = '0;
`endif
    for (int i = 0; i < N; i++) begin prio_m[i] = 0; model_pend[i] = 1'b0; end
    repeat (3) @(negedge clk);
    vectors++;
    if ({int_gen, int_addr, int_pending, int_in_service, int_active_level, dbg_state} !== 21'd0) begin
      miscompares++;
      $display("FAIL reset_outputs: gen=%b addr=%h pend=%h svc=%b lvl=%0d st=%0d expected all 0",
               int_gen, int_addr, int_pending, int_in_service, int_active_level, dbg_state);
    end
    reset_n = 1'b1; global_int_enable = 1'b1; int_enable_mask = 8'hFF;
    @(negedge clk);
  endtask

  task automatic test_single_pulse();
    logic [3:0] seq;
    set_prio(3, 1);
    @(negedge clk);
    int_pins = 8'h08; model_pend[3] = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      int_pins = '0;
      seq[k] = int_gen;
    end
    vectors++;
    if (seq !== 4'b1000) begin
      miscompares++;
      $display("FAIL latency: int_gen after edges t..t+3 got %b expected 1000 (lsb first)", seq);
    end
    vectors++;
    if (int_addr !== 8'h1B) begin miscompares++; $display("FAIL pulse_addr: got %h expected 1b", int_addr); end
    do_ack(3);
    vectors++;
    if ({int_gen, int_pending[3], int_in_service, int_active_level} !== 5'b00101) begin
      miscompares++;
      $display("FAIL pulse_ack: gen/pend3/svc/lvl got %b/%b/%b/%0d expected 0/0/1/1",
               int_gen, int_pending[3], int_in_service, int_active_level);
    end
    vectors++;
    if (int_addr !== 8'h1B) begin miscompares++; $display("FAIL addr_hold: got %h expected 1b", int_addr); end
    do_ret();
    vectors++;
    if (int_in_service !== 1'b0) begin miscompares++; $display("FAIL pulse_ret: svc got %b expected 0", int_in_service); end
  endtask

  task automatic test_tie();
    bit ok;
    set_prio(2, 2); set_prio(5, 2);
    pulse_pins(8'h24);
    wait_gen(10, ok);
    vectors++;
    if (!ok || int_addr !== 8'h13) begin miscompares++; $display("FAIL tie_first: gen=%b addr %h expected 13", ok, int_addr); end
    do_ack(2);
    do_ret();
    wait_gen(10, ok);
    vectors++;
    if (!ok || int_addr !== 8'h2B) begin miscompares++; $display("FAIL tie_second: gen=%b addr %h expected 2b", ok, int_addr); end
    do_ack(5);
    do_ret();
  endtask

  task automatic test_preempt();
    bit ok;
    set_prio(1, 1); set_prio(6, 3);
    pulse_pins(8'h02);
    wait_gen(10, ok);
    do_ack(1);
    int_ack = 1'b1;
    @(negedge clk);
    int_ack = 1'b0;
    vectors++;
    if ({int_in_service, int_active_level} !== 3'b101) begin
      miscompares++;
      $display("FAIL stray_ack: svc/lvl got %b/%0d expected 1/1", int_in_service, int_active_level);
    end
    pulse_pins(8'h40);
    wait_gen(10, ok);
    vectors++;
    if (!ok || int_addr !== 8'h33) begin miscompares++; $display("FAIL preempt_addr: gen=%b addr %h expected 33", ok, int_addr); end
    do_ack(6);
    vectors++;
    if (int_active_level !== 2'd3) begin miscompares++; $display("FAIL preempt_lvl: got %0d expected 3", int_active_level); end
    do_ret();
    vectors++;
    if ({int_in_service, int_active_level} !== 3'b101) begin
      miscompares++;
      $display("FAIL preempt_pop1: svc/lvl got %b/%0d expected 1/1", int_in_service, int_active_level);
    end
    do_ret();
    vectors++;
    if (int_in_service !== 1'b0) begin miscompares++; $display("FAIL preempt_pop2: svc got %b expected 0", int_in_service); end
  endtask

  task automatic test_same_level();
    bit ok, seen;
    set_prio(2, 2); set_prio(4, 2);
    pulse_pins(8'h04);
    wait_gen(10, ok);
    do_ack(2);
    pulse_pins(8'h10);
    quiet(8, seen);
    vectors++;
    if (seen) begin miscompares++; $display("FAIL same_level_block: int_gen got 1 expected 0"); end
    do_ret();
    wait_gen(10, ok);
    vectors++;
    if (!ok || int_addr !== 8'h23) begin miscompares++; $display("FAIL same_level_addr: gen=%b addr %h expected 23", ok, int_addr); end
    do_ack(4);
    do_ret();
  endtask

  task automatic test_ack_ret_same_cycle();
    bit ok;
    set_prio(1, 1); set_prio(6, 3);
    pulse_pins(8'h02);
    wait_gen(10, ok);
    do_ack(1);
    pulse_pins(8'h40);
    wait_gen(10, ok);
    ret_int = 1'b1;
    void'(stk_lvl_q.pop_back()); void'(stk_id_q.pop_back());
    do_ack(6);
    ret_int = 1'b0;
    vectors++;
    if ({int_in_service, int_active_level, dbg_top_id} !== 6'b111110) begin
      miscompares++;
      $display("FAIL ack_ret_replace: svc/lvl/id got %b/%0d/%0d expected 1/3/6",
               int_in_service, int_active_level, dbg_top_id);
    end
    do_ret();
    vectors++;
    if (int_in_service !== 1'b0) begin miscompares++; $display("FAIL ack_ret_pop: svc got %b expected 0", int_in_service); end
  endtask

  task automatic test_withdraw();
    bit ok, dropped;
    int_level1_pulse0 = 8'h01;
    set_prio(0, 0);
    @(negedge clk);
    int_pins = 8'h01;
    wait_gen(10, ok);
    vectors++;
    if (!ok || int_addr !== 8'h03) begin miscompares++; $display("FAIL level_addr: gen=%b addr %h expected 03", ok, int_addr); end
    int_pins = '0;
    dropped = 1'b0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      if (int_gen === 1'b0) begin dropped = 1'b1; break; end
    end
    vectors++;
    if (!dropped) begin miscompares++; $display("FAIL withdraw_gen: int_gen got 1 expected 0"); end
    vectors++;
    if ({int_in_service, int_pending[0]} !== 2'b00) begin
      miscompares++;
      $display("FAIL withdraw_state: svc/pend0 got %b/%b expected 0/0", int_in_service, int_pending[0]);
    end
    int_level1_pulse0 = '0;
  endtask

  task automatic test_global_disable();
    bit ok, seen;
    global_int_enable = 1'b0;
    set_prio(7, 2);
    pulse_pins(8'h80);
    quiet(8, seen);
    vectors++;
    if (seen || int_pending !== 8'h80) begin
      miscompares++;
      $display("FAIL global_off: gen_seen=%b pend %h expected 0/80", seen, int_pending);
    end
    global_int_enable = 1'b1;
    wait_gen(10, ok);
    vectors++;
    if (!ok || int_addr !== 8'h3B) begin miscompares++; $display("FAIL global_on: gen=%b addr %h expected 3b", ok, int_addr); end
    do_ack(7);
    do_ret();
  endtask

`ifdef INT_SW_TRIGGER_EN
  task automatic test_sw_trigger();
    bit ok;
    set_prio(4, 2);
    @(negedge clk);
    sw_int_set = 8'h10; model_pend[4] = 1'b1;
    @(negedge clk);
    sw_int_set = '0;
    wait_gen(10, ok);
    vectors++;
    if (!ok || int_addr !== 8'h23 || int_pending[4] !== 1'b1) begin
      miscompares++;
      $display("FAIL sw_trigger: gen=%b addr %h pend4 %b expected 1/23/1", ok, int_addr, int_pending[4]);
    end
    do_ack(4);
    vectors++;
    if (int_pending[4] !== 1'b0) begin miscompares++; $display("FAIL sw_clear: pend4 got %b expected 0", int_pending[4]); end
    do_ret();
  endtask
`endif

  task automatic test_random();
    logic [7:0] m;
    for (int phase = 0; phase < 3; phase++) begin
      int_enable_mask = (phase == 2) ? 8'hFF : 8'($urandom_range(1, 255));
      for (int i = 0; i < N; i++) set_prio(i, $urandom_range(0, 3));
      drain();
      for (int round = 0; round < 20; round++) begin
        m = 8'($urandom & $urandom);
        pulse_pins(m);
        repeat (5) @(negedge clk);
        vectors++;
        if (int_pending !== pend_vec()) begin
          miscompares++;
          $display("FAIL rand_pending: got %h expected %h", int_pending, pend_vec());
        end
        drain();
        repeat ($urandom_range(0, 2)) begin
          if (stk_lvl_q.size() != 0) begin
            do_ret();
            drain();
          end
        end
      end
      int_enable_mask = 8'hFF;
      drain();
      for (int k = 0; k < 40 && stk_lvl_q.size() != 0; k++) begin
        do_ret();
        drain();
      end
      vectors++;
      if ({int_in_service, int_pending} !== 9'd0) begin
        miscompares++;
        $display("FAIL rand_unwind: svc/pend got %b/%h expected 0/00", int_in_service, int_pending);
      end
    end
  endtask

  initial begin
    vectors = 0;
    miscompares = 0;
    test_reset();
    test_single_pulse();
    test_tie();
    test_preempt();
    test_same_level();
    test_ack_ret_same_cycle();
    test_withdraw();
    test_global_disable();
`ifdef INT_SW_TRIGGER_EN
    test_sw_trigger();
`endif
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
